// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer feeding a 4-bit ALU stage one nibble per
// cycle, least-significant first. It chains the ALU carry between nibbles,
// assembles the wide result and returns it over a valid/ready handshake.
//
// Optional feature macro: ALU_SEQ_ACC_EN
//   When defined, the i_cmd_acc port exists. With i_cmd_acc = 1 at acceptance,
//   operand A is taken from the current result register instead of i_cmd_a.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_a, i_cmd_b          W-bit operands (W = 4*NIBBLES)
//   i_cmd_sel, i_cmd_cin      ALU select and carry-in for nibble 0
//   i_cmd_acc                 accumulate from previous result (ALU_SEQ_ACC_EN)
//   o_alu_a/b/sel/cin         current nibble drive to the ALU (0 outside EXEC)
//   i_alu_g, i_alu_cout       ALU result for the current nibble
//   o_res_valid/i_res_ready   result handshake
//   o_res_data, o_res_cout    assembled result, carry-out of the last nibble
//   o_res_zero                o_res_data == 0
module alu_seq_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [4*NIBBLES-1:0]   i_cmd_a,
   input  logic [4*NIBBLES-1:0]   i_cmd_b,
   input  logic [2:0]             i_cmd_sel,
   input  logic                   i_cmd_cin,
`ifdef ALU_SEQ_ACC_EN
   input  logic                   i_cmd_acc,
`endif
   output logic [3:0]             o_alu_a,
   output logic [3:0]             o_alu_b,
   output logic [2:0]             o_alu_sel,
   output logic                   o_alu_cin,
   input  logic [3:0]             i_alu_g,
   input  logic                   i_alu_cout,
   output logic                   o_res_valid,
   input  logic                   i_res_ready,
   output logic [4*NIBBLES-1:0]   o_res_data,
   output logic                   o_res_cout,
   output logic                   o_res_zero
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned KW = $clog2(NIBBLES);
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [KW-1:0]   k_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    res_q;
   logic [2:0]      sel_q;
   logic            cin_q;
   logic            carry_q;
   logic            res_cout_q;
   logic            cmd_ready_q;
   logic            res_valid_q;
   logic            exec;
   logic [W-1:0]    a_src;

   // Operand A source at acceptance
`ifdef ALU_SEQ_ACC_EN
   assign a_src = i_cmd_acc ? res_q : i_cmd_a;
`else
   assign a_src = i_cmd_a;
`endif

   // Sequencer FSM with registered handshake flags
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         sel_q       <= '0;
         cin_q       <= 1'b0;
         carry_q     <= 1'b0;
         res_cout_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // cmd_ready_q stays low in the first post-reset cycle, so the
               // release edge itself never accepts a command
               if (cmd_ready_q && i_cmd_valid) begin
                  a_q         <= a_src;
                  b_q         <= i_cmd_b;
                  sel_q       <= i_cmd_sel;
                  cin_q       <= i_cmd_cin;
                  k_q         <= '0;
                  cmd_ready_q <= 1'b0;
                  state_q     <= EXEC;
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            EXEC: begin
               res_q[4*k_q +: 4] <= i_alu_g;
               carry_q           <= i_alu_cout;
               if (k_q == K_LAST) begin
                  res_cout_q  <= i_alu_cout;
                  res_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (i_res_ready) begin
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign exec = (state_q == EXEC);

   // ALU drive decoded from registered state; quiet outside EXEC
   assign o_alu_a   = exec ? 4'(a_q >> {k_q, 2'b00}) : 4'h0;
   assign o_alu_b   = exec ? 4'(b_q >> {k_q, 2'b00}) : 4'h0;
   assign o_alu_sel = exec ? sel_q : 3'b000;
   assign o_alu_cin = exec & ((k_q == '0) ? cin_q : carry_q);

   assign o_cmd_ready = cmd_ready_q;
   assign o_res_valid = res_valid_q;
   assign o_res_data  = res_q;
   assign o_res_cout  = res_cout_q;
   assign o_res_zero  = (res_q == '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural 4-bit ALU
// (add for sel[2] = 0, AND for sel[2] = 1) and a wide-word reference model.
module tb_alu_seq_ctrl;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [W-1:0]  i_cmd_a;
   logic [W-1:0]  i_cmd_b;
   logic [2:0]    i_cmd_sel;
   logic          i_cmd_cin;
   logic          i_cmd_acc;
   logic [3:0]    o_alu_a;
   logic [3:0]    o_alu_b;
   logic [2:0]    o_alu_sel;
   logic          o_alu_cin;
   logic [3:0]    i_alu_g;
   logic          i_alu_cout;
   logic          o_res_valid;
   logic          i_res_ready;
   logic [W-1:0]  o_res_data;
   logic          o_res_cout;
   logic          o_res_zero;

   int total = 0;
   int bad   = 0;

   alu_seq_ctrl #(.NIBBLES(NIB)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_a     (i_cmd_a),
      .i_cmd_b     (i_cmd_b),
      .i_cmd_sel   (i_cmd_sel),
      .i_cmd_cin   (i_cmd_cin),
`ifdef ALU_SEQ_ACC_EN
      .i_cmd_acc   (i_cmd_acc),
`endif
      .o_alu_a     (o_alu_a),
      .o_alu_b     (o_alu_b),
      .o_alu_sel   (o_alu_sel),
      .o_alu_cin   (o_alu_cin),
      .i_alu_g     (i_alu_g),
      .i_alu_cout  (i_alu_cout),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_data  (o_res_data),
      .o_res_cout  (o_res_cout),
      .o_res_zero  (o_res_zero)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural ALU slice
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum = 5'(o_alu_a) + 5'(o_alu_b) + 5'(o_alu_cin);
      if (o_alu_sel[2]) begin
         i_alu_g    = o_alu_a & o_alu_b;
         i_alu_cout = 1'b0;
      end else begin
         i_alu_g    = alu_sum[3:0];
         i_alu_cout = alu_sum[4];
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Wide-word reference: whole-operand add or AND
   task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input logic cin,
                         output logic [W-1:0] d, output logic co,
                         output logic [3:0] cins);
      logic [W:0] s;
      if (sel[2]) begin
         d = a & b; co = 1'b0; cins = {3'b000, cin};
      end else begin
         s = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
         d = s[W-1:0]; co = s[W];
         cins[0] = cin;
         for (int k = 1; k < 4; k++) begin
            s = (W+1)'(a & ((1 << (4*k)) - 1)) + (W+1)'(b & ((1 << (4*k)) - 1)) + (W+1)'(cin);
            cins[k] = s[4*k];
         end
      end
   endtask

   // Observe EXEC from the cycle after acceptance until o_res_valid
   task automatic wait_result(output int lat, output logic [3:0] cins,
                              output logic [W-1:0] oa, output logic [W-1:0] ob,
                              output logic [2:0] osel);
      lat = 1; cins = '0; oa = '0; ob = '0; osel = '0;
      while (!o_res_valid && lat < 20) begin
         if (lat <= 4) begin
            cins[lat-1]       = o_alu_cin;
            oa[4*(lat-1) +: 4] = o_alu_a;
            ob[4*(lat-1) +: 4] = o_alu_b;
         end
         if (lat == 1) osel = o_alu_sel;
         step();
         lat++;
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input logic cin, input logic acc,
                         output int lat, output logic [3:0] cins,
                         output logic [W-1:0] oa, output logic [W-1:0] ob,
                         output logic [2:0] osel, output logic [W-1:0] d,
                         output logic co, output logic z, output logic rdy_after);
      int n = 0;
      while (!o_cmd_ready && n < 20) begin step(); n++; end
      i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b;
      i_cmd_sel = sel; i_cmd_cin = cin; i_cmd_acc = acc;
      step();
      i_cmd_valid = 1'b0; i_cmd_acc = 1'b0;
      wait_result(lat, cins, oa, ob, osel);
      d = o_res_data; co = o_res_cout; z = o_res_zero;
      step();
      rdy_after = o_cmd_ready;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      step(); step();
      total++; if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", o_cmd_ready); end
      total++; if (o_res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_res_valid); end
      total++; if (o_res_data !== 16'h0 || o_res_zero !== 1'b1 || o_res_cout !== 1'b0) begin
         bad++; $display("FAIL reset_result got=%h/%b/%b want=0000/1/0", o_res_data, o_res_zero, o_res_cout); end
      total++; if ({o_alu_a, o_alu_b, o_alu_sel, o_alu_cin} !== 12'h0) begin
         bad++; $display("FAIL reset_alu_idle got=%h want=000", {o_alu_a, o_alu_b, o_alu_sel, o_alu_cin}); end
      i_rst_n = 1'b1;
      step();
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", o_cmd_ready); end
   endtask

   task automatic test_fixed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] sel, input logic cin,
                             input logic [W-1:0] ed, input logic eco, input logic ez,
                             input logic [3:0] ecins);
      int lat; logic [3:0] cins; logic [W-1:0] oa, ob, d; logic [2:0] osel; logic co, z, r;
      run_op(a, b, sel, cin, 1'b0, lat, cins, oa, ob, osel, d, co, z, r);
      total++; if (d !== ed) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, d, ed); end
      total++; if (co !== eco || z !== ez) begin bad++; $display("FAIL %s_flags got=%b%b want=%b%b", nm, co, z, eco, ez); end
      total++; if (lat != 5) begin bad++; $display("FAIL %s_latency got=%0d want=5", nm, lat); end
      total++; if (cins !== ecins) begin bad++; $display("FAIL %s_cin_seq got=%b want=%b", nm, cins, ecins); end
      total++; if (r !== 1'b1) begin bad++; $display("FAIL %s_ready_after got=%b want=1", nm, r); end
   endtask

   task automatic test_backpressure();
      int lat; logic [3:0] cins; logic [W-1:0] oa, ob, held; logic [2:0] osel;
      logic [W-1:0] ed; logic eco; logic [3:0] ec; int errs = 0;
      i_res_ready = 1'b0;
      i_cmd_valid = 1'b1; i_cmd_a = 16'h1234; i_cmd_b = 16'h1111; i_cmd_sel = 3'b000; i_cmd_cin = 1'b0;
      step();
      // second command offered throughout the stall
      i_cmd_a = 16'h00F0; i_cmd_b = 16'h0F0F; i_cmd_sel = 3'b100; i_cmd_cin = 1'b0;
      wait_result(lat, cins, oa, ob, osel);
      held = o_res_data;
      total++; if (held !== 16'h2345) begin bad++; $display("FAIL bp_first_data got=%h want=2345", held); end
      for (int i = 0; i < 10; i++) begin
         if (o_res_valid !== 1'b1 || o_res_data !== held || o_cmd_ready !== 1'b0) errs++;
         step();
      end
      total++; if (errs != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0 bad cycles", errs); end
      i_res_ready = 1'b1;
      step();
      total++; if (o_cmd_ready !== 1'b1 || o_res_valid !== 1'b0 || o_alu_sel !== 3'b000) begin
         bad++; $display("FAIL bp_exit got=rdy%b vld%b sel%b want=rdy1 vld0 sel000", o_cmd_ready, o_res_valid, o_alu_sel); end
      step();
      i_cmd_valid = 1'b0;
      wait_result(lat, cins, oa, ob, osel);
      ref_op(16'h00F0, 16'h0F0F, 3'b100, 1'b0, ed, eco, ec);
      total++; if (lat != 5 || oa !== 16'h00F0 || o_res_data !== ed) begin
         bad++; $display("FAIL bp_second got=lat%0d a%h d%h want=lat5 a00f0 d%h", lat, oa, o_res_data, ed); end
      step();
   endtask

   task automatic test_reset_mid();
      int n; int seen = 0;
      i_cmd_valid = 1'b1; i_cmd_a = 16'h0FFF; i_cmd_b = 16'h0001; i_cmd_sel = 3'b000; i_cmd_cin = 1'b0;
      n = 0; while (!o_cmd_ready && n < 20) begin step(); n++; end
      step();
      i_cmd_valid = 1'b0;
      step(); step();
      total++; if (o_alu_a !== 4'hF || o_alu_cin !== 1'b1) begin
         bad++; $display("FAIL rmid_nibble2 got=a%h cin%b want=aF cin1", o_alu_a, o_alu_cin); end
      i_rst_n = 1'b0;
      step();
      total++; if (o_res_valid !== 1'b0 || o_cmd_ready !== 1'b0 || o_res_data !== 16'h0) begin
         bad++; $display("FAIL rmid_held got=vld%b rdy%b d%h want=vld0 rdy0 d0000", o_res_valid, o_cmd_ready, o_res_data); end
      step();
      i_rst_n = 1'b1;
      step();
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_release_ready got=%b want=1", o_cmd_ready); end
      for (int i = 0; i < 8; i++) begin if (o_res_valid) seen++; step(); end
      total++; if (seen != 0 || o_res_data !== 16'h0) begin
         bad++; $display("FAIL rmid_no_result got=%0d valid cycles d%h want=0 d0000", seen, o_res_data); end
   endtask

   task automatic test_random();
      int lat; logic [3:0] cins, ec; logic [W-1:0] oa, ob, d, a, b, ed; logic [2:0] osel, sel;
      logic co, z, r, cin, eco;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom); sel = 3'($urandom); cin = 1'($urandom);
         if (i == 3) begin a = 16'hFFFF; b = 16'h0001; end
         ref_op(a, b, sel, cin, ed, eco, ec);
         run_op(a, b, sel, cin, 1'b0, lat, cins, oa, ob, osel, d, co, z, r);
         total++; if (d !== ed || co !== eco || z !== (ed == '0)) begin
            bad++; $display("FAIL rnd%0d_result got=%h/%b/%b want=%h/%b/%b", i, d, co, z, ed, eco, ed == '0); end
         total++; if (oa !== a || ob !== b || osel !== sel || cins !== ec) begin
            bad++; $display("FAIL rnd%0d_alu_drive got=%h %h %b %b want=%h %h %b %b", i, oa, ob, osel, cins, a, b, sel, ec); end
         total++; if (lat != 5 || r !== 1'b1) begin
            bad++; $display("FAIL rnd%0d_timing got=lat%0d rdy%b want=lat5 rdy1", i, lat, r); end
      end
   endtask

`ifdef ALU_SEQ_ACC_EN
   task automatic test_acc();
      int lat; logic [3:0] cins; logic [W-1:0] oa, ob, d; logic [2:0] osel; logic co, z, r;
      run_op(16'h0003, 16'h0004, 3'b000, 1'b0, 1'b0, lat, cins, oa, ob, osel, d, co, z, r);
      total++; if (d !== 16'h0007) begin bad++; $display("FAIL acc_first got=%h want=0007", d); end
      run_op(16'hFFFF, 16'h0010, 3'b000, 1'b0, 1'b1, lat, cins, oa, ob, osel, d, co, z, r);
      total++; if (d !== 16'h0017 || oa !== 16'h0007) begin bad++; $display("FAIL acc_chain got=%h a%h want=0017 a0007", d, oa); end
   endtask
`endif

   initial begin
      i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_a = '0; i_cmd_b = '0;
      i_cmd_sel = '0; i_cmd_cin = 1'b0; i_cmd_acc = 1'b0; i_res_ready = 1'b1;
      test_reset();
      test_fixed("carry", 16'h0FFF, 16'h0001, 3'b000, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110);
      test_fixed("ovf",   16'hFFFF, 16'h0000, 3'b000, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1111);
      test_fixed("logic", 16'hA5C3, 16'h0FF0, 3'b100, 1'b1, 16'h05C0, 1'b0, 1'b0, 4'b0001);
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef ALU_SEQ_ACC_EN
      test_acc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle operation sequencer that sits directly upstream of the 4-bit ALU stage. It accepts a wide (4·NIBBLES-bit) command over a valid/ready handshake and drives the ALU one nibble per cycle, least-significant first. It chains the ALU carry-out into the next nibble's carry-in, assembles the wide result, and presents it downstream over a second valid/ready handshake.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; data width W = 4·NIBBLES; minimum 2.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  sequencer can accept a command.
- i_cmd_a, i_cmd_b  in  W  operands.
- i_cmd_sel  in  3  ALU select; bit 2 = 1 is a logic op, bits 1:0 select the op.
- i_cmd_cin  in  1  carry-in for nibble 0.
- i_cmd_acc  in  1  use previous result as operand A; present only with ALU_SEQ_ACC_EN.
- o_alu_a, o_alu_b  out  4  current nibble operands to the ALU.
- o_alu_sel  out  3  select to the ALU.
- o_alu_cin  out  1  carry-in to the ALU.
- i_alu_g  in  4  ALU result for the current nibble; combinational, same cycle.
- i_alu_cout  in  1  ALU carry-out; 0 for logic ops.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  downstream accepts the result.
- o_res_data  out  W  assembled result.
- o_res_cout  out  1  carry-out of the last nibble.
- o_res_zero  out  1  o_res_data == 0.

## Operation
- FSM states:
  - IDLE: o_cmd_ready = 1.
  - EXEC: nibble counter k runs 0..NIBBLES-1.
  - DONE: o_res_valid = 1.
- IDLE→EXEC on i_cmd_valid & o_cmd_ready. The operands, sel and cin are latched on this edge, and k is cleared.
- In EXEC, nibble k of the latched operands drives o_alu_a and o_alu_b. o_alu_sel is the latched sel.
- o_alu_cin is the latched cin when k = 0, otherwise the carry register.
- Each EXEC cycle captures i_alu_g into result nibble k and i_alu_cout into the carry register.
- EXEC→DONE after capturing k = NIBBLES-1. o_res_cout equals the last captured cout.
- DONE→IDLE on i_res_ready. o_res_data, o_res_cout and o_res_zero hold stable while o_res_valid = 1 and remain readable in IDLE until the next result is written.
- Outside EXEC, o_alu_a, o_alu_b, o_alu_sel and o_alu_cin are all 0.
- Command inputs are ignored in EXEC and DONE (o_cmd_ready = 0). Only one command is in flight.
- Logic ops need no special-casing: the ALU returns cout = 0, so the chain carries 0.

## Timing
- Command handshake in cycle T → nibble k on the ALU ports in cycle T+1+k → o_res_valid rises in cycle T+NIBBLES+1.
- With i_res_ready held high: DONE lasts 1 cycle and o_cmd_ready rises at T+NIBBLES+2. Throughput is one op per NIBBLES+2 cycles.
- i_res_ready low: stay in DONE indefinitely with all outputs frozen.
- All outputs are registered or decoded from registered state. There is no combinational path from i_cmd_valid or i_res_ready to any output.
- Reset (i_rst_n = 0 at an edge), including mid-EXEC or mid-DONE:
  - state goes to IDLE; the in-flight op is discarded and no o_res_valid is produced;
  - result, carry and accumulator registers clear to 0;
  - o_res_valid = 0 and o_cmd_ready = 0 while reset is held;
  - o_cmd_ready = 1 in the first cycle after release.

## Configuration
- ALU_SEQ_ACC_EN defined:
  - the i_cmd_acc port exists;
  - when i_cmd_acc = 1 at acceptance, operand A is latched from the current result register instead of i_cmd_a; after reset this value is 0;
  - this enables chained accumulation without a round trip.
- ALU_SEQ_ACC_EN undefined: the port is absent and operand A always comes from i_cmd_a.

## Test plan
The bench ALU model is add when sel[2] = 0 (g = a+b+cin, cout = carry) and AND when sel[2] = 1 (cout = 0). NIBBLES = 4.
- Carry propagation: a = 0x0FFF, b = 0x0001, sel = 000, cin = 0 → o_res_data = 0x1000, cout = 0, zero = 0. o_res_valid asserts exactly 5 cycles after acceptance, with o_alu_cin = 0,1,1,1 over the four nibbles.
- Overflow and zero flag: 0xFFFF + 0x0000 with cin = 1 → data = 0x0000, cout = 1, zero = 1.
- Logic op: 0xA5C3 AND 0x0FF0, sel = 100, cin = 1 → data = 0x05C0, cout = 0. o_alu_cin is 0 for nibbles 1–3.
- Backpressure: i_res_ready held low for 10 cycles → o_res_valid and o_res_data stay stable and o_cmd_ready stays 0. The command offered during that window is accepted only in the cycle after DONE exits.
- Reset mid-op: assert i_rst_n = 0 during nibble 2 → o_res_valid never asserts for that op, data reads 0 after reset, and o_cmd_ready = 1 in the first cycle after release.
- ALU_SEQ_ACC_EN: 0x0003 + 0x0004 = 0x0007, then acc = 1 with b = 0x0010 → 0x0017.
